// File: rtl/step_updown_counter.sv
// step_updown_counter
// Up/down counter advancing by a fixed STEP per enabled clock edge.
// Supports synchronous parallel load, wrap or saturate at the range limits,
// and a registered one-cycle ovf flag for every step that hits a boundary.
// Load has priority over counting; with en low the count holds.

module step_updown_counter #(
  parameter int unsigned      WIDTH   = 4,
  parameter int unsigned      STEP    = 2,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up_dn,
  input  logic             sat_mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             ovf
);

  // STEP in WIDTH+1 bits exposes the carry on the way up; the WIDTH-bit
  // copy is enough for the modulo subtraction on the way down.
  localparam logic [WIDTH:0]   STEP_X = (WIDTH + 1)'(STEP);
  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

  logic [WIDTH-1:0] count_r;
  logic             ovf_r;

  logic [WIDTH:0]   up_sum_s;
  logic [WIDTH-1:0] dn_diff_s;
  logic             up_bnd_s;
  logic             dn_bnd_s;
  logic [WIDTH-1:0] stepped_s;
  logic             bnd_s;
  logic [WIDTH-1:0] count_nxt_s;
  logic             ovf_nxt_s;

  // Candidate step in the selected direction and whether it leaves the range.
  always_comb begin
    up_sum_s  = {1'b0, count_r} + STEP_X;
    dn_diff_s = count_r - STEP_W;
    // Carry out of the top bit means the sum exceeded 2**WIDTH-1.
    up_bnd_s  = up_sum_s[WIDTH];
    // Borrow: the step is larger than what is left above zero.
    dn_bnd_s  = ({1'b0, count_r} < STEP_X);
    if (up_dn) begin
      stepped_s = up_sum_s[WIDTH-1:0];
      bnd_s     = up_bnd_s;
    end else begin
      stepped_s = dn_diff_s;
      bnd_s     = dn_bnd_s;
    end
  end

  // Next-state selection: load beats counting, counting beats hold.
  always_comb begin
    count_nxt_s = count_r;
    ovf_nxt_s   = 1'b0;
    if (load) begin
      count_nxt_s = load_val;
      ovf_nxt_s   = 1'b0;
    end else if (en) begin
      if (bnd_s) begin
        ovf_nxt_s = 1'b1;
        if (sat_mode) begin
          // Refuse the step entirely so the value keeps its residue mod STEP.
          count_nxt_s = count_r;
        end else begin
          count_nxt_s = stepped_s;
        end
      end else begin
        count_nxt_s = stepped_s;
        ovf_nxt_s   = 1'b0;
      end
    end else begin
      count_nxt_s = count_r;
      ovf_nxt_s   = 1'b0;
    end
  end

  // State registers with asynchronous reset to RST_VAL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= RST_VAL;
      ovf_r   <= 1'b0;
    end else begin
      count_r <= count_nxt_s;
      ovf_r   <= ovf_nxt_s;
    end
  end

  assign count = count_r;
  assign ovf   = ovf_r;

endmodule

// File: tb/tb_step_updown_counter.sv
// Bench for step_updown_counter: a default instance (WIDTH=4, STEP=2,
// RST_VAL=0) and a swept instance (WIDTH=8, STEP=3, RST_VAL=250) run on the
// same control inputs. An integer-arithmetic model tracks both and is compared
// every falling edge; directed literal checks pin the model to known sequences.

module tb_step_updown_counter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       up_dn = 1'b0;
  logic       sat_mode = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_val_a = 4'd0;
  logic [7:0] load_val_b = 8'd0;
  logic [3:0] count_a;
  logic [7:0] count_b;
  logic       ovf_a;
  logic       ovf_b;

  int  n_tests = 0;
  int  n_fail  = 0;
  bit  chk_on  = 1'b0;
  int  ma_cnt  = 0;
  bit  ma_ovf  = 1'b0;
  int  mb_cnt  = 250;
  bit  mb_ovf  = 1'b0;

  step_updown_counter #(.WIDTH(4), .STEP(2), .RST_VAL(4'd0)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .sat_mode(sat_mode),
    .load(load), .load_val(load_val_a), .count(count_a), .ovf(ovf_a)
  );

  step_updown_counter #(.WIDTH(8), .STEP(3), .RST_VAL(8'd250)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .sat_mode(sat_mode),
    .load(load), .load_val(load_val_b), .count(count_b), .ovf(ovf_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input int exp);
    n_tests++;
    if (act !== 32'(exp)) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Range arithmetic on plain integers: step, detect leaving [0, 2**w-1],
  // then wrap modulo 2**w or refuse the step.
  function automatic int model_next(input int cur, input int w, input int stp,
                                    input bit e, input bit u, input bit s,
                                    input bit l, input int lv, output bit o);
    int span;
    int v;
    span = 1 << w;
    o = 1'b0;
    if (l) return lv;
    if (!e) return cur;
    v = u ? cur + stp : cur - stp;
    if (v < 0 || v >= span) begin
      o = 1'b1;
      if (s) return cur;
      return (v < 0) ? v + span : v - span;
    end
    return v;
  endfunction

  // Reference model state for both instances.
  always @(posedge clk or negedge rst_n) begin : model
    int  na, nb;
    bit  oa, ob;
    if (!rst_n) begin
      ma_cnt <= 0;
      ma_ovf <= 1'b0;
      mb_cnt <= 250;
      mb_ovf <= 1'b0;
    end else begin
      na = model_next(ma_cnt, 4, 2, en, up_dn, sat_mode, load, int'(load_val_a), oa);
      nb = model_next(mb_cnt, 8, 3, en, up_dn, sat_mode, load, int'(load_val_b), ob);
      ma_cnt <= na;
      ma_ovf <= oa;
      mb_cnt <= nb;
      mb_ovf <= ob;
    end
  end

  // Every-cycle comparison of both DUTs against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      check("model_count_a", 32'(count_a), ma_cnt);
      check("model_ovf_a",   32'(ovf_a),   int'(ma_ovf));
      check("model_count_b", 32'(count_b), mb_cnt);
      check("model_ovf_b",   32'(ovf_b),   int'(mb_ovf));
    end
  end

  task automatic set_ctl(input bit e, input bit u, input bit s, input bit l,
                         input logic [3:0] lva, input logic [7:0] lvb);
    en = e; up_dn = u; sat_mode = s; load = l;
    load_val_a = lva; load_val_b = lvb;
  endtask

  int down_seq [9] = '{14, 12, 10, 8, 6, 4, 2, 0, 14};
  bit down_ovf [9] = '{1, 0, 0, 0, 0, 0, 0, 0, 1};
  int up_a_seq [3] = '{14, 0, 2};
  bit up_a_ovf [3] = '{0, 1, 0};
  int sw_b_seq [3] = '{253, 0, 3};
  bit sw_b_ovf [3] = '{0, 1, 0};
  int sw_a_seq [3] = '{2, 4, 6};

  initial begin
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    chk_on = 1'b1;
    check("reset_count_a", 32'(count_a), 0);
    check("reset_ovf_a",   32'(ovf_a),   0);
    check("reset_count_b", 32'(count_b), 250);

    // Swept instance counts up from its reset value and wraps.
    set_ctl(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("sweep_count_b", 32'(count_b), sw_b_seq[i]);
      check("sweep_ovf_b",   32'(ovf_b),   int'(sw_b_ovf[i]));
      check("sweep_count_a", 32'(count_a), sw_a_seq[i]);
    end

    // Asynchronous reset between edges while count_a is 6.
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_count_a", 32'(count_a), 0);
    check("async_rst_ovf_a",   32'(ovf_a),   0);
    check("async_rst_count_b", 32'(count_b), 250);
    repeat (2) @(negedge clk);
    check("rst_held_count_a", 32'(count_a), 0);
    set_ctl(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0);
    rst_n = 1'b1;

    // Down wrap with default parameters.
    set_ctl(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      check("down_count_a", 32'(count_a), down_seq[i]);
      check("down_ovf_a",   32'(ovf_a),   int'(down_ovf[i]));
    end

    // Up wrap from a loaded 12.
    set_ctl(1'b0, 1'b0, 1'b0, 1'b1, 4'd12, 8'd1);
    @(negedge clk);
    check("load12_count_a", 32'(count_a), 12);
    check("load_count_b",   32'(count_b), 1);
    set_ctl(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("up_count_a", 32'(count_a), up_a_seq[i]);
      check("up_ovf_a",   32'(ovf_a),   int'(up_a_ovf[i]));
    end

    // Saturate at the top, then step back down.
    set_ctl(1'b0, 1'b1, 1'b1, 1'b1, 4'd14, 8'd254);
    @(negedge clk);
    check("load14_count_a", 32'(count_a), 14);
    set_ctl(1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 8'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("sat_count_a", 32'(count_a), 14);
      check("sat_ovf_a",   32'(ovf_a),   1);
      check("sat_count_b", 32'(count_b), 254);
    end
    up_dn = 1'b0;
    @(negedge clk);
    check("sat_down_count_a", 32'(count_a), 12);
    check("sat_down_ovf_a",   32'(ovf_a),   0);

    // Load wins over a simultaneous enabled step.
    set_ctl(1'b1, 1'b1, 1'b0, 1'b1, 4'd5, 8'd7);
    @(negedge clk);
    check("prio_count_a", 32'(count_a), 5);
    check("prio_ovf_a",   32'(ovf_a),   0);
    set_ctl(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0);
    repeat (2) begin
      @(negedge clk);
      check("hold_count_a", 32'(count_a), 5);
      check("hold_ovf_a",   32'(ovf_a),   0);
    end

    // Random control traffic, checked by the model every cycle.
    for (int i = 0; i < 1000; i++) begin
      set_ctl(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0),
              4'($urandom), 8'($urandom));
      @(negedge clk);
    end

    chk_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
